i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
I2S serializer between the core's audio mixer and the board's external stereo DAC (MCLK/SCLK/LRCLK/SDIN pins). It runs from the 28 MHz system clock. It derives all DAC clocks from one free-running frame counter and double-buffers 16-bit left/right samples. It shifts the samples out MSB-first in standard I2S format: one-bit delay after LRCLK, 32 SCLK slots per channel.

Parameters:
UNSIGNED_IN, 1, 1 = inputs are offset binary (core mixer output, zero-padded to 16 bits) and bit 15 is inverted to give two's complement; 0 = inputs are already two's complement and pass unchanged.

Ports:
clk  input  1  system clock, 28 MHz
rst  input  1  asynchronous reset, active-high
left_in  input  16  left sample
right_in  input  16  right sample
sample_we  input  1  when high on a clk edge, left_in/right_in are captured into the holding registers
sample_tick  output  1  one-clk pulse when holding registers are transferred to the active (shifting) registers
mclk  output  1  DAC master clock, clk/2 = 14 MHz
sclk  output  1  bit clock, clk/8 = 3.5 MHz
lrclk  output  1  word select, clk/512 = 54687.5 Hz; 0 = left, 1 = right
sdin  output  1  serial data

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: cnt[8:0] = 0, hold_l = hold_r = 0, act_l = act_r = 0. Outputs mclk, sclk, lrclk, sdin and sample_tick all = 0. Reset mid-frame aborts the frame immediately; there is no partial-word completion.
- Counter: cnt increments by 1 every clk edge and wraps 511 -> 0.
- Output derivation: every output is a register computed from the pre-edge value of cnt. Output latency is therefore one clk: outputs seen while cnt = N+1 describe cnt = N.
  - mclk = cnt[0]
  - sclk = cnt[2]
  - lrclk = cnt[8]
- Slot index: s = cnt[7:3] (0..31); channel = cnt[8].
- SCLK edges: the falling edge occurs when cnt[2:0] wraps 7 -> 0. sdin changes only on those edges; the DAC samples sdin on the SCLK rising edge.
- sdin by slot:
  - s = 0: 0 (one-bit I2S delay).
  - s = 1..16: bit (16 - s) of the channel's active word, i.e. MSB in slot 1 and LSB in slot 16.
  - s = 17..31: 0.
- Input conversion at capture: the captured word is {in[15] ^ UNSIGNED_IN, in[14:0]}.
- Holding registers: load on any clk edge where sample_we = 1; otherwise they hold. With no new writes, the last sample repeats every frame.
- Frame transfer: on the edge where cnt == 511, act_l <= hold_l and act_r <= hold_r. sample_tick is 1 for exactly the following clk (while cnt = 0) and 0 otherwise.
- Simultaneous write and transfer: if sample_we = 1 on the cnt == 511 edge, the active registers receive the OLD holding values. The new sample goes out in the next frame. This holds because holding and active registers update on the same edge.
- Multiple writes in one frame: the last write before the cnt == 511 edge wins.
- Frame timing: the left word is transmitted while lrclk = 0 and the right word while lrclk = 1, both from the same transfer. One frame is 512 clk, with MCLK/LRCLK = 256 and SCLK/LRCLK = 64.
- No combinational path from inputs to outputs.

Test Plan:
- Reset release -> first edge: all outputs 0. mclk toggles every clk, sclk period is 8 clk, lrclk period is 512 clk with 50% duty. The first lrclk rise is seen at the edge after cnt = 256.
- UNSIGNED_IN=1; write left_in = 0xC000, right_in = 0x4000 once before cnt = 511 -> after sample_tick, the left slot bits read on sclk rising edges are 0,0100000000000000,0... The right slot bits are 0,1100000000000000,0...
- UNSIGNED_IN=0; write left_in = 0x8001, right_in = 0x7FFE -> the left slot carries 1000000000000001 in slots 1..16 and the right slot carries 0111111111111110. Slots 0 and 17..31 read 0.
- sample_we asserted exactly on the cnt == 511 edge with 0x1234 after a prior 0x0F0F (UNSIGNED_IN=0) -> the next frame sends 0x0F0F and the frame after sends 0x1234. sample_tick pulses once per 512 clk.
- No writes for 3 frames after a single write of 0xAAAA/0x5555 (UNSIGNED_IN=0) -> identical serial data in all 3 frames.
- rst asserted asynchronously mid-slot (cnt = 300) -> all outputs are 0 before the next clk edge. After release, timing restarts from cnt = 0 and the holding registers are cleared (sdin all 0).

Source files
------------

// File: rtl/i2s_dac_tx_if.sv
// Sample bus and DAC pin bundle for the I2S transmitter.
// The mixer side drives samples (master); the transmitter drives the pins (slave).
interface i2s_dac_tx_if;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        sample_we;
    logic        sample_tick;
    logic        mclk;
    logic        sclk;
    logic        lrclk;
    logic        sdin;

    modport master (
        output left_in, right_in, sample_we,
        input  sample_tick, mclk, sclk, lrclk, sdin
    );

    modport slave (
        input  left_in, right_in, sample_we,
        output sample_tick, mclk, sclk, lrclk, sdin
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S serializer: one 9-bit frame counter derives MCLK/SCLK/LRCLK, and the
// double-buffered 16-bit stereo samples are shifted out MSB-first with a one-slot delay.
module i2s_dac_tx #(
    parameter bit UNSIGNED_IN = 1'b1
) (
    input logic        clk,
    input logic        rst,
    i2s_dac_tx_if.slave bus
);

    logic [8:0]  cnt_q;
    logic [15:0] hold_l_q, hold_r_q;
    logic [15:0] act_l_q, act_r_q;
    logic        mclk_q, sclk_q, lrclk_q, sdin_q, tick_q;

    logic        frame_end;
    logic [4:0]  slot;
    logic [3:0]  bit_idx;
    logic [15:0] cur_word;
    logic        sdin_d;
    logic [15:0] conv_l, conv_r;

    always_comb begin
        frame_end = (cnt_q == 9'd511);
        slot      = cnt_q[7:3];
        // Slot 1 carries bit 15, slot 16 carries bit 0
        bit_idx   = 4'(5'd16 - slot);
        cur_word  = cnt_q[8] ? act_r_q : act_l_q;
        sdin_d    = 1'b0;
        if (slot >= 5'd1 && slot <= 5'd16) begin
            sdin_d = cur_word[bit_idx];
        end
        conv_l = {bus.left_in[15] ^ UNSIGNED_IN, bus.left_in[14:0]};
        conv_r = {bus.right_in[15] ^ UNSIGNED_IN, bus.right_in[14:0]};
    end

    // Holding and active registers share an edge, so a write on the transfer
    // edge lands in the holding pair while the old value moves to active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            act_l_q  <= '0;
            act_r_q  <= '0;
            mclk_q   <= 1'b0;
            sclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdin_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 9'd1;
            if (bus.sample_we) begin
                hold_l_q <= conv_l;
                hold_r_q <= conv_r;
            end
            if (frame_end) begin
                act_l_q <= hold_l_q;
                act_r_q <= hold_r_q;
            end
            mclk_q  <= cnt_q[0];
            sclk_q  <= cnt_q[2];
            lrclk_q <= cnt_q[8];
            sdin_q  <= sdin_d;
            tick_q  <= frame_end;
        end
    end

    assign bus.mclk        = mclk_q;
    assign bus.sclk        = sclk_q;
    assign bus.lrclk       = lrclk_q;
    assign bus.sdin        = sdin_q;
    assign bus.sample_tick = tick_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed and randomized bench for i2s_dac_tx; dut index 0 uses two's complement
// inputs, index 1 uses offset-binary inputs. Serial data is decoded on SCLK rises.
module tb_i2s_dac_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] drv_l = '0;
    logic [15:0] drv_r = '0;
    logic        drv_we = 1'b0;

    i2s_dac_tx_if bus_s ();
    i2s_dac_tx_if bus_u ();

    assign bus_s.left_in   = drv_l;
    assign bus_s.right_in  = drv_r;
    assign bus_s.sample_we = drv_we;
    assign bus_u.left_in   = drv_l;
    assign bus_u.right_in  = drv_r;
    assign bus_u.sample_we = drv_we;

    i2s_dac_tx #(.UNSIGNED_IN(1'b0)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    i2s_dac_tx #(.UNSIGNED_IN(1'b1)) dut_u (.clk(clk), .rst(rst), .bus(bus_u));

    logic [1:0] mclk_w, sclk_w, lrclk_w, sdin_w, tick_w;
    assign mclk_w  = {bus_u.mclk, bus_s.mclk};
    assign sclk_w  = {bus_u.sclk, bus_s.sclk};
    assign lrclk_w = {bus_u.lrclk, bus_s.lrclk};
    assign sdin_w  = {bus_u.sdin, bus_s.sdin};
    assign tick_w  = {bus_u.sample_tick, bus_s.sample_tick};

    int tests = 0;
    int fails = 0;
    int k = 0;  // clk edges since reset release
    int m = 0;  // counter value the current outputs describe

    logic        bits   [0:1][0:1][0:31];
    logic [15:0] m_hold [0:1][0:1];
    logic [15:0] m_act  [0:1][0:1];
    logic [15:0] last_w [0:1][0:1];
    logic [1:0]  sclk_prev;
    logic [15:0] ref_l, ref_r;

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                m_hold[d][c] = '0;
                m_act[d][c]  = '0;
            end
        end
        sclk_prev = 2'b00;
        k = 0;
    endtask

    function automatic logic [15:0] conv(input int d, input logic [15:0] v);
        return (d == 1) ? (v ^ 16'h8000) : v;
    endfunction

    task automatic check_frame();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                logic [15:0] w;
                int pad;
                w = '0;
                pad = 0;
                for (int s = 0; s < 32; s++) begin
                    if (s >= 1 && s <= 16) w = {w[14:0], bits[d][c][s]};
                    else if (bits[d][c][s] !== 1'b0) pad++;
                end
                chk(c ? "pad_r" : "pad_l", d, pad, 0);
                chk(c ? "word_r" : "word_l", d, w, m_act[d][c]);
                last_w[d][c] = w;
            end
        end
    endtask

    // One clk: inputs already set are captured on the edge, outputs checked at negedge.
    task automatic step();
        logic        we_now;
        logic [15:0] l_now, r_now;
        @(posedge clk);
        we_now = drv_we;
        l_now  = drv_l;
        r_now  = drv_r;
        @(negedge clk);
        k++;
        m = (k - 1) % 512;
        for (int d = 0; d < 2; d++) begin
            chk("mclk", d, mclk_w[d], m & 1);
            chk("sclk", d, sclk_w[d], (m >> 2) & 1);
            chk("lrclk", d, lrclk_w[d], (m >> 8) & 1);
            chk("tick", d, tick_w[d], (m == 511) ? 1 : 0);
            if (sclk_w[d] && !sclk_prev[d]) bits[d][m >> 8][(m >> 3) & 31] = sdin_w[d];
        end
        if (m == 511) begin
            check_frame();
            for (int d = 0; d < 2; d++) begin
                m_act[d][0] = m_hold[d][0];
                m_act[d][1] = m_hold[d][1];
            end
        end
        if (we_now) begin
            for (int d = 0; d < 2; d++) begin
                m_hold[d][0] = conv(d, l_now);
                m_hold[d][1] = conv(d, r_now);
            end
        end
        sclk_prev = sclk_w;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic to_frame_end();
        do step(); while (k % 512 != 0);
    endtask

    task automatic write(input logic [15:0] l, input logic [15:0] r);
        drv_l  = l;
        drv_r  = r;
        drv_we = 1'b1;
        step();
        drv_we = 1'b0;
        drv_l  = 16'($urandom);
        drv_r  = 16'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk(tag, d, {mclk_w[d], sclk_w[d], lrclk_w[d], sdin_w[d], tick_w[d]}, 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++)
                for (int s = 0; s < 32; s++) bits[d][c][s] = 1'bx;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        model_clear();

        // Offset binary vs two's complement conversion
        steps(10);
        write(16'hC000, 16'h4000);
        to_frame_end();
        to_frame_end();
        chk("ub_left", 1, last_w[1][0], 16'h4000);
        chk("ub_right", 1, last_w[1][1], 16'hC000);
        chk("tc_left", 0, last_w[0][0], 16'hC000);
        chk("tc_right", 0, last_w[0][1], 16'h4000);

        // Extreme bit patterns, with a discarded earlier write in the same frame
        steps(50);
        write(16'($urandom), 16'($urandom));
        steps(30);
        write(16'h8001, 16'h7FFE);
        to_frame_end();
        to_frame_end();
        chk("tc_8001", 0, last_w[0][0], 16'h8001);
        chk("tc_7ffe", 0, last_w[0][1], 16'h7FFE);
        chk("ub_8001", 1, last_w[1][0], 16'h0001);
        chk("ub_7ffe", 1, last_w[1][1], 16'hFFFE);

        // Write coinciding with the transfer edge
        steps(40);
        write(16'h0F0F, 16'h0F0F);
        while (k % 512 != 511) step();
        write(16'h1234, 16'h1234);
        to_frame_end();
        chk("old_on_xfer", 0, last_w[0][0], 16'h0F0F);
        to_frame_end();
        chk("new_after_xfer", 0, last_w[0][0], 16'h1234);
        chk("new_after_xfer_r", 0, last_w[0][1], 16'h1234);

        // Random samples, then repeats with no further writes
        for (int i = 0; i < 3; i++) begin
            steps(int'($urandom_range(5, 400)));
            write(16'($urandom), 16'($urandom));
            to_frame_end();
            to_frame_end();
        end
        steps(20);
        write(16'hAAAA, 16'h5555);
        to_frame_end();
        for (int f = 0; f < 3; f++) begin
            to_frame_end();
            chk("repeat_l", 0, last_w[0][0], 16'hAAAA);
            chk("repeat_r", 0, last_w[0][1], 16'h5555);
        end

        // Asynchronous reset mid-slot
        while (k % 512 != 300) step();
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        to_frame_end();
        to_frame_end();
        chk("cleared_l", 0, last_w[0][0], 16'h0000);
        chk("cleared_r", 0, last_w[0][1], 16'h0000);
        chk("cleared_ub", 1, last_w[1][0], 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
